// File: rtl/led_panel_rx.sv
// HUB75 panel emulator: oversamples the panel pins, rebuilds each latched row and
// streams it out as pixel writes, reporting per-row unblanked time and protocol errors.
module led_panel_rx #(
  parameter int COLS      = 64,
  parameter int ADDR_BITS = 5,
  parameter int ON_BITS   = 16,
  localparam int CB       = $clog2(COLS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 led_sclk_i,
  input  logic                 led_latch_i,
  input  logic                 led_blank_i,
  input  logic [ADDR_BITS-1:0] led_addr_i,
  input  logic [2:0]           led_rgb0_i,
  input  logic [2:0]           led_rgb1_i,
  output logic                 px_valid_o,
  input  logic                 px_ready_i,
  output logic [CB-1:0]        px_x_o,
  output logic [ADDR_BITS:0]   px_y_o,
  output logic [2:0]           px_rgb_o,
  output logic                 on_valid_o,
  output logic [ADDR_BITS-1:0] on_addr_o,
  output logic [ON_BITS-1:0]   on_cycles_o,
  output logic                 col_err_o,
  output logic                 overrun_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    DUMP0 = 3'b010,
    DUMP1 = 3'b100
  } state_t;

  localparam logic [CB:0]   COL_FULL = (CB+1)'(COLS);
  localparam logic [CB:0]   COL_MAX  = (CB+1)'(2*COLS-1);
  localparam logic [CB-1:0] X_LAST   = CB'(COLS-1);

  logic                 sclk_s1_q, sclk_s2_q, latch_s1_q, latch_s2_q, blank_s1_q;
  logic [ADDR_BITS-1:0] addr_s1_q;
  logic [2:0]           rgb0_s1_q, rgb1_s1_q;
  logic                 sclk_rise, latch_rise;

  logic [COLS-1:0][5:0] shift_q, shift_d, row_q, row_d;
  logic [CB:0]          col_cnt_q, col_cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ON_BITS-1:0]   on_cnt_q, on_cnt_d;
  logic                 have_prev_q, have_prev_d;
  logic                 on_valid_q, on_valid_d;
  logic [ADDR_BITS-1:0] on_addr_q, on_addr_d;
  logic [ON_BITS-1:0]   on_cycles_q, on_cycles_d;
  logic                 col_err_q, col_err_d;
  logic                 overrun_q, overrun_d;

  state_t               state_q, state_d;
  logic [CB-1:0]        x_q, x_d;

  assign sclk_rise  = sclk_s1_q & ~sclk_s2_q;
  assign latch_rise = latch_s1_q & ~latch_s2_q;

  assign on_valid_o  = on_valid_q;
  assign on_addr_o   = on_addr_q;
  assign on_cycles_o = on_cycles_q;
  assign col_err_o   = col_err_q;
  assign overrun_o   = overrun_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      latch_s1_q <= 1'b0;
      latch_s2_q <= 1'b0;
      blank_s1_q <= 1'b0;
      addr_s1_q  <= '0;
      rgb0_s1_q  <= '0;
      rgb1_s1_q  <= '0;
    end else begin
      sclk_s1_q  <= led_sclk_i;
      sclk_s2_q  <= sclk_s1_q;
      latch_s1_q <= led_latch_i;
      latch_s2_q <= latch_s1_q;
      blank_s1_q <= led_blank_i;
      addr_s1_q  <= led_addr_i;
      rgb0_s1_q  <= led_rgb0_i;
      rgb1_s1_q  <= led_rgb1_i;
    end
  end

  always_comb begin
    shift_d     = shift_q;
    col_cnt_d   = col_cnt_q;
    row_d       = row_q;
    addr_d      = addr_q;
    on_cnt_d    = on_cnt_q;
    have_prev_d = have_prev_q;
    on_valid_d  = 1'b0;
    on_addr_d   = '0;
    on_cycles_d = '0;
    col_err_d   = 1'b0;
    overrun_d   = 1'b0;

    // Newest column enters at the top so the first-shifted one ends at x = 0.
    if (sclk_rise) begin
      shift_d = {{rgb1_s1_q, rgb0_s1_q}, shift_q[COLS-1:1]};
      if (col_cnt_q != COL_MAX) col_cnt_d = col_cnt_q + 1'b1;
    end

    if (!blank_s1_q && (on_cnt_q != '1)) on_cnt_d = on_cnt_q + 1'b1;

    // Uses the post-shift view so a coincident SCLK edge belongs to this row.
    if (latch_rise) begin
      col_err_d = (col_cnt_d != COL_FULL);
      col_cnt_d = '0;
      if (state_q != IDLE) begin
        overrun_d = 1'b1;
      end else begin
        row_d       = shift_d;
        addr_d      = addr_s1_q;
        on_cnt_d    = '0;
        have_prev_d = 1'b1;
        if (have_prev_q) begin
          on_valid_d  = 1'b1;
          on_addr_d   = addr_q;
          on_cycles_d = on_cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q     <= '0;
      col_cnt_q   <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      on_cnt_q    <= '0;
      have_prev_q <= 1'b0;
      on_valid_q  <= 1'b0;
      on_addr_q   <= '0;
      on_cycles_q <= '0;
      col_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      col_cnt_q   <= col_cnt_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      on_cnt_q    <= on_cnt_d;
      have_prev_q <= have_prev_d;
      on_valid_q  <= on_valid_d;
      on_addr_q   <= on_addr_d;
      on_cycles_q <= on_cycles_d;
      col_err_q   <= col_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    px_valid_o = 1'b0;
    px_x_o     = '0;
    px_y_o     = '0;
    px_rgb_o   = '0;
    case (state_q)
      IDLE: begin
        if (latch_rise) begin
          state_d = DUMP0;
          x_d     = '0;
        end
      end
      DUMP0: begin
        px_valid_o = 1'b1;
        px_x_o     = x_q;
        px_y_o     = {1'b0, addr_q};
        px_rgb_o   = row_q[x_q][2:0];
        if (px_ready_i) begin
          if (x_q == X_LAST) begin
            state_d = DUMP1;
            x_d     = '0;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DUMP1: begin
        px_valid_o = 1'b1;
        px_x_o     = x_q;
        px_y_o     = {1'b1, addr_q};
        px_rgb_o   = row_q[x_q][5:3];
        if (px_ready_i) begin
          if (x_q == X_LAST) begin
            state_d = IDLE;
            x_d     = '0;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
      end
    endcase
  end

endmodule
